writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 150 +++++++++++++++
 tb/tb_writeback_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Writes ALU results one cycle after
// acceptance; for loads it waits for the memory response, extracts and
// extends the addressed byte/half/word, then writes one cycle later.
// Optional feature macro: WB_RETIRE_CNT_EN adds the outRetireCount port.
module writeback_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        inValid,
  output logic        outReady,
  input  logic        inRegWrite,
  input  logic        inMemOrReg,
  input  logic [4:0]  inDestRegister,
  input  logic [63:0] inAluResult,
  input  logic [2:0]  inLoadType,
  input  logic        inMemRespValid,
  input  logic [63:0] inMemRespData,
  output logic        outMemRespReady,
  output logic        outRegWrite,
  output logic [4:0]  outDestRegister,
  output logic [63:0] outRegData,
  output logic        outStall
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0] outRetireCount
`endif
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        load_accept;
  logic        resp_fire;
  logic [4:0]  pend_rd;
  logic [2:0]  pend_off;
  logic [2:0]  pend_type;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] sel_word;
  logic [63:0] load_data;

  // State register; reset abandons any pending load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next      = state;
    outReady        = 1'b0;
    outMemRespReady = 1'b0;
    accept          = 1'b0;
    load_accept     = 1'b0;
    resp_fire       = 1'b0;
    unique case (state)
      IDLE: begin
        outReady = 1'b1;
        accept   = inValid;
        if (inValid && inMemOrReg && inRegWrite) begin
          load_accept = 1'b1;
          state_next  = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        outMemRespReady = 1'b1;
        if (inMemRespValid) begin
          resp_fire  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign outStall = ~outReady;

  // Capture the load's destination, address offset and access type.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_rd   <= '0;
      pend_off  <= '0;
      pend_type <= '0;
    end else if (load_accept) begin
      pend_rd   <= inDestRegister;
      pend_off  <= inAluResult[2:0];
      pend_type <= inLoadType;
    end
  end

  // Lane selection and sign/zero extension of the response doubleword.
  always_comb begin
    sel_byte  = 8'(inMemRespData >> {pend_off, 3'b000});
    sel_half  = 16'(inMemRespData >> {pend_off[2:1], 4'b0000});
    sel_word  = 32'(inMemRespData >> {pend_off[2], 5'b00000});
    load_data = inMemRespData;
    unique case (pend_type)
      3'b001:  load_data = {{56{sel_byte[7]}}, sel_byte};
      3'b010:  load_data = {{48{sel_half[15]}}, sel_half};
      3'b011:  load_data = {{32{sel_word[31]}}, sel_word};
      3'b100:  load_data = {56'd0, sel_byte};
      3'b101:  load_data = {48'd0, sel_half};
      3'b110:  load_data = {32'd0, sel_word};
      default: load_data = inMemRespData;
    endcase
  end

  // Register-file write port: one-cycle strobe, index/data hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outRegWrite     <= 1'b0;
      outDestRegister <= '0;
      outRegData      <= '0;
    end else begin
      outRegWrite <= 1'b0;
      if (resp_fire) begin
        if (pend_rd != 5'd0) begin
          outRegWrite     <= 1'b1;
          outDestRegister <= pend_rd;
          outRegData      <= load_data;
        end
      end else if (accept && !load_accept && inRegWrite &&
                   (inDestRegister != 5'd0)) begin
        outRegWrite     <= 1'b1;
        outDestRegister <= inDestRegister;
        outRegData      <= inAluResult;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Retire count: writes as they happen, non-writing instructions at acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outRetireCount <= '0;
    end else begin
      outRetireCount <= outRetireCount + 64'(outRegWrite) +
                        64'(accept && (!inRegWrite || (inDestRegister == 5'd0)));
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: the driver pushes expected register
// writes (index, data, cycle) and a negedge monitor checks every cycle.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        outReady;
  logic        inRegWrite;
  logic        inMemOrReg;
  logic [4:0]  inDestRegister;
  logic [63:0] inAluResult;
  logic [2:0]  inLoadType;
  logic        inMemRespValid;
  logic [63:0] inMemRespData;
  logic        outMemRespReady;
  logic        outRegWrite;
  logic [4:0]  outDestRegister;
  logic [63:0] outRegData;
  logic        outStall;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] outRetireCount;
`endif

  writeback_stage dut (
    .clk             (clk),
    .reset           (reset),
    .inValid         (inValid),
    .outReady        (outReady),
    .inRegWrite      (inRegWrite),
    .inMemOrReg      (inMemOrReg),
    .inDestRegister  (inDestRegister),
    .inAluResult     (inAluResult),
    .inLoadType      (inLoadType),
    .inMemRespValid  (inMemRespValid),
    .inMemRespData   (inMemRespData),
    .outMemRespReady (outMemRespReady),
    .outRegWrite     (outRegWrite),
    .outDestRegister (outDestRegister),
    .outRegData      (outRegData),
    .outStall        (outStall)
`ifdef WB_RETIRE_CNT_EN
    ,
    .outRetireCount  (outRetireCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [4:0]  last_rd = '0;
  logic [63:0] last_data = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference load result: aligned lane by access size, then extend.
  function automatic logic [63:0] load_model(input logic [2:0] t,
                                             input logic [63:0] addr,
                                             input logic [63:0] data);
    int unsigned size;
    bit          sgn;
    int unsigned base;
    logic [63:0] mask;
    logic [63:0] v;
    case (t)
      3'd1: begin size = 1; sgn = 1; end
      3'd2: begin size = 2; sgn = 1; end
      3'd3: begin size = 4; sgn = 1; end
      3'd4: begin size = 1; sgn = 0; end
      3'd5: begin size = 2; sgn = 0; end
      3'd6: begin size = 4; sgn = 0; end
      default: begin size = 8; sgn = 0; end
    endcase
    if (size == 8) return data;
    base = (32'(addr % 8) / size) * size;
    mask = (64'd1 << (size * 8)) - 64'd1;
    v    = (data >> (base * 8)) & mask;
    if (sgn && v[size*8-1]) v = v | ~mask;
    return v;
  endfunction

  // Monitor: every cycle the strobe must match the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      last_rd   = '0;
      last_data = '0;
    end else begin
      bit exp_pulse;
      exp_t e;
      exp_pulse = (sb.size() > 0) && (sb[0].cyc == cyc);
      chk("stall_vs_ready", 64'(outStall), 64'(!outReady));
      chk("write_strobe", 64'(outRegWrite), 64'(exp_pulse));
      if (exp_pulse) begin
        e = sb.pop_front();
        if (outRegWrite) begin
          chk("write_rd", 64'(outDestRegister), 64'(e.rd));
          chk("write_data", outRegData, e.data);
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        void'(sb.pop_front());
      end
      if (outRegWrite) begin
        last_rd   = outDestRegister;
        last_data = outRegData;
      end else begin
        chk("hold_rd", 64'(outDestRegister), 64'(last_rd));
        chk("hold_data", outRegData, last_data);
      end
    end
  end

  task automatic push_exp(input logic [4:0] rd, input logic [63:0] data);
    exp_t e;
    e.rd = rd; e.data = data; e.cyc = cyc;
    if (rd != 5'd0) sb.push_back(e);
  endtask

  task automatic idle();
    inValid        = 1'b0;
    inMemRespValid = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [63:0] res,
                     input logic rw, input logic mor);
    inValid        = 1'b1;
    inRegWrite     = rw;
    inMemOrReg     = mor;
    inDestRegister = rd;
    inAluResult    = res;
    inLoadType     = 3'($urandom);
    inMemRespValid = 1'($urandom);
    inMemRespData  = {$urandom, $urandom};
    @(posedge clk); #1;
    if (rw) push_exp(rd, res);
    chk("alu_ready_after", 64'(outReady), 64'd1);
  endtask

  task automatic load(input logic [2:0] t, input logic [63:0] addr,
                      input logic [4:0] rd, input logic [63:0] data,
                      input int unsigned delay, input logic [63:0] expv);
    inValid        = 1'b1;
    inRegWrite     = 1'b1;
    inMemOrReg     = 1'b1;
    inDestRegister = rd;
    inAluResult    = addr;
    inLoadType     = t;
    inMemRespValid = 1'b0;
    @(posedge clk); #1;
    chk("load_stall", 64'(outStall), 64'd1);
    chk("load_resp_ready", 64'(outMemRespReady), 64'd1);
    for (int i = 0; i < int'(delay); i++) begin
      inValid        = 1'($urandom);
      inRegWrite     = 1'($urandom);
      inMemOrReg     = 1'($urandom);
      inDestRegister = 5'($urandom);
      inAluResult    = {$urandom, $urandom};
      inMemRespValid = 1'b0;
      inMemRespData  = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("wait_stall", 64'(outStall), 64'd1);
    end
    inMemRespValid = 1'b1;
    inMemRespData  = data;
    @(posedge clk); #1;
    push_exp(rd, expv);
    chk("resp_ready_done", 64'(outReady), 64'd1);
    chk("resp_mem_ready_off", 64'(outMemRespReady), 64'd0);
    idle();
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", 64'(outReady), 64'd1);
    chk("rst_stall", 64'(outStall), 64'd0);
    chk("rst_mem_ready", 64'(outMemRespReady), 64'd0);
    chk("rst_write", 64'(outRegWrite), 64'd0);
    chk("rst_rd", 64'(outDestRegister), 64'd0);
    chk("rst_data", outRegData, 64'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_retire", outRetireCount, 64'd0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    logic [2:0]  t;
    reset = 1'b1;
    inRegWrite = 1'b0; inMemOrReg = 1'b0; inDestRegister = '0;
    inAluResult = '0; inLoadType = '0; inMemRespData = '0;
    idle();
    @(posedge clk); #1;
    do_reset();

    // Basic ALU write, then idle cycle with no strobe.
    alu(5'd5, 64'h1234, 1'b1, 1'b0);
    idle();
    @(posedge clk); #1;

    // Byte loads with the 0x80 byte at offset 3.
    load(3'b001, 64'h1003, 5'd7, 64'h0000_0000_8000_0000, 2, 64'hFFFF_FFFF_FFFF_FF80);
    load(3'b100, 64'h1003, 5'd7, 64'h0000_0000_8000_0000, 0, 64'h0000_0000_0000_0080);
    // Upper word, sign-extended.
    load(3'b011, 64'h1004, 5'd9, 64'h8000_0001_0000_0002, 3, 64'hFFFF_FFFF_8000_0001);
    // Halfword ignores address bit 0; unsigned word; type 111 acts as ld.
    load(3'b010, 64'h2007, 5'd10, 64'h8001_2345_6789_abcd, 1, 64'hFFFF_FFFF_FFFF_8001);
    load(3'b110, 64'h2005, 5'd11, 64'h8001_2345_6789_abcd, 0, 64'h0000_0000_8001_2345);
    load(3'b111, 64'h2005, 5'd12, 64'hdead_beef_0bad_f00d, 1, 64'hdead_beef_0bad_f00d);

    // rd = 0: no writes; load still consumes only one response.
    alu(5'd0, 64'h55, 1'b1, 1'b0);
    load(3'b000, 64'h3000, 5'd0, 64'h1, 1, 64'h0);
    inMemRespValid = 1'b1;
    inMemRespData  = 64'hffff;
    @(posedge clk); #1;
    chk("extra_resp_ignored", 64'(outReady), 64'd1);
    idle();

    // Reset while a load is pending: abandoned, later response ignored.
    inValid = 1'b1; inRegWrite = 1'b1; inMemOrReg = 1'b1;
    inDestRegister = 5'd3; inAluResult = 64'h4000; inLoadType = 3'b011;
    @(posedge clk); #1;
    inValid = 1'b0;
    chk("pend_resp_ready", 64'(outMemRespReady), 64'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    inMemRespValid = 1'b1;
    inMemRespData  = 64'h7777;
    repeat (2) begin
      @(posedge clk); #1;
      chk("post_rst_mem_ready", 64'(outMemRespReady), 64'd0);
      chk("post_rst_ready", 64'(outReady), 64'd1);
    end
    idle();

`ifdef WB_RETIRE_CNT_EN
    do_reset();
    alu(5'd1, 64'h1, 1'b1, 1'b0);
    alu(5'd2, 64'h2, 1'b1, 1'b0);
    alu(5'd3, 64'h3, 1'b1, 1'b0);
    load(3'b000, 64'h10, 5'd4, 64'h4, 1, 64'h4);
    repeat (3) @(posedge clk);
    #1;
    chk("retire_count_4", outRetireCount, 64'd4);
    do_reset();
`endif

    // Randomized mix of ALU ops, non-writing ops and loads.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 6) begin
        logic rw;
        rw = 1'($urandom);
        alu(5'($urandom), {$urandom, $urandom}, rw, rw ? 1'b0 : 1'($urandom));
      end else begin
        t = 3'($urandom);
        a = {$urandom, $urandom};
        d = {$urandom, $urandom};
        load(t, a, 5'($urandom), d, $urandom_range(0, 3), load_model(t, a, d));
      end
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end
    end
    idle();
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
